// File: rtl/mem_port_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : mem_port_sched                                                  |
// | Desc   : Load/store memory-port arbiter with an in-flight load tag table. |
// |          Optional macro MEM_SCHED_STARVE_EN enables load anti-starvation. |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module mem_port_sched #(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic        ld_squash,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [63:0] st_data,
  input  logic [3:0]  mem_resp_tag,
  input  logic [3:0]  mem_data_tag,
  input  logic [63:0] mem_data,
  output logic [1:0]  mem_cmd,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        ld_stall,
  output logic        st_stall,
  output logic        ld_data_ready,
  output logic [31:0] ld_base_addr,
  output logic [63:0] ld_data,
  output logic [3:0]  inflight_cnt
);

  localparam logic [1:0] c_CMD_NONE  = 2'd0;
  localparam logic [1:0] c_CMD_LOAD  = 2'd1;
  localparam logic [1:0] c_CMD_STORE = 2'd2;

  logic [OUTSTANDING-1:0] r_valid;
  logic [OUTSTANDING-1:0] r_squashed;
  logic [3:0]             r_tag  [OUTSTANDING];
  logic [31:0]            r_addr [OUTSTANDING];
  logic [3:0]             r_inflight_cnt;

  logic                   w_full;
  logic                   w_starved;
  logic                   w_ld_grant;
  logic                   w_st_grant;
  logic                   w_ld_accept;
  logic                   w_st_accept;
  logic                   w_free_seen;
  logic                   w_hit;
  logic                   w_hit_sq;
  logic [31:0]            w_hit_addr;
  logic [OUTSTANDING-1:0] w_alloc;
  logic [OUTSTANDING-1:0] w_release;
  logic [OUTSTANDING-1:0] w_valid_next;
  logic [3:0]             w_cnt_next;

  // Fullness is judged on the current table, so a same-cycle free never admits a load.
  assign w_full      = &r_valid;
  assign w_ld_grant  = !reset && ld_req && !w_full && (!st_req || w_starved);
  assign w_st_grant  = !reset && st_req && !w_ld_grant;
  assign w_ld_accept = w_ld_grant && (mem_resp_tag != 4'd0);
  assign w_st_accept = w_st_grant && (mem_resp_tag != 4'd0);

`ifdef MEM_SCHED_STARVE_EN
  localparam int c_SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  logic [c_SC_W-1:0] r_starve_cnt;

  assign w_starved = (r_starve_cnt == c_SC_W'(STARVE_LIMIT));

  always_ff @(posedge clock) begin
    if (reset || !ld_req || w_ld_accept) begin
      r_starve_cnt <= '0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + c_SC_W'(1);
    end
  end
`else
  assign w_starved = 1'b0;
`endif

  always_comb begin
    w_alloc     = '0;
    w_free_seen = 1'b0;
    for (int i = 0; i < OUTSTANDING; i++) begin
      if (!w_free_seen && !r_valid[i]) begin
        w_free_seen = 1'b1;
        w_alloc[i]  = w_ld_accept;
      end
    end
  end

  always_comb begin
    w_release  = '0;
    w_hit      = 1'b0;
    w_hit_sq   = 1'b0;
    w_hit_addr = '0;
    for (int i = 0; i < OUTSTANDING; i++) begin
      if (!w_hit && r_valid[i] && (mem_data_tag != 4'd0) && (r_tag[i] == mem_data_tag)) begin
        w_hit        = 1'b1;
        w_release[i] = 1'b1;
        w_hit_sq     = r_squashed[i];
        w_hit_addr   = r_addr[i];
      end
    end
  end

  always_comb begin
    w_valid_next = (r_valid & ~w_release) | w_alloc;
    w_cnt_next   = '0;
    for (int i = 0; i < OUTSTANDING; i++) begin
      w_cnt_next = w_cnt_next + {3'b000, w_valid_next[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid        <= '0;
      r_squashed     <= '0;
      r_inflight_cnt <= '0;
    end else begin
      r_valid        <= w_valid_next;
      r_inflight_cnt <= w_cnt_next;
      for (int i = 0; i < OUTSTANDING; i++) begin
        // A freshly allocated entry belongs to the post-squash stream.
        if (w_alloc[i]) begin
          r_tag[i]      <= mem_resp_tag;
          r_addr[i]     <= ld_addr;
          r_squashed[i] <= 1'b0;
        end else if (ld_squash && r_valid[i]) begin
          r_squashed[i] <= 1'b1;
        end
      end
    end
  end

  assign mem_cmd       = w_ld_grant ? c_CMD_LOAD : (w_st_grant ? c_CMD_STORE : c_CMD_NONE);
  assign mem_addr      = w_ld_grant ? ld_addr : (w_st_grant ? st_addr : 32'd0);
  assign mem_wdata     = w_st_grant ? st_data : 64'd0;
  assign ld_stall      = ld_req && !w_ld_accept;
  assign st_stall      = st_req && !w_st_accept;
  assign ld_data_ready = w_hit && !w_hit_sq && !ld_squash && !reset;
  assign ld_base_addr  = ld_data_ready ? w_hit_addr : 32'd0;
  assign ld_data       = ld_data_ready ? mem_data : 64'd0;
  assign inflight_cnt  = r_inflight_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_mem_port_sched                                               |
// | Desc   : Vector table, directed corner sequences and random run against  |
// |          a tag-keyed reference model (honours MEM_SCHED_STARVE_EN).      |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_mem_port_sched;

  localparam int OUT = 4;
  localparam int SL  = 4;
`ifdef MEM_SCHED_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_req, ld_squash, st_req;
  logic [31:0] ld_addr, st_addr;
  logic [63:0] st_data, mem_data;
  logic [3:0]  mem_resp_tag, mem_data_tag;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr, ld_base_addr;
  logic [63:0] mem_wdata, ld_data;
  logic        ld_stall, st_stall, ld_data_ready;
  logic [3:0]  inflight_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_sched #(.OUTSTANDING(OUT), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_squash(ld_squash), .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .mem_resp_tag(mem_resp_tag), .mem_data_tag(mem_data_tag), .mem_data(mem_data),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ld_stall(ld_stall), .st_stall(st_stall), .ld_data_ready(ld_data_ready),
    .ld_base_addr(ld_base_addr), .ld_data(ld_data), .inflight_cnt(inflight_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit rst; bit ld; logic [31:0] la; bit sq; bit st; logic [31:0] sa; logic [63:0] sd;
    logic [3:0] rt; logic [3:0] dt; logic [63:0] md;
    logic [1:0] ecmd; logic [31:0] eaddr; logic [63:0] ewd; bit els; bit ess;
    bit erdy; logic [31:0] ebase; logic [63:0] edata; logic [3:0] ecnt;
  } vec_t;

  function automatic vec_t mk(bit rst, bit ld, logic [31:0] la, bit sq, bit st,
                              logic [31:0] sa, logic [63:0] sd, logic [3:0] rt,
                              logic [3:0] dt, logic [63:0] md, logic [1:0] ecmd,
                              logic [31:0] eaddr, logic [63:0] ewd, bit els, bit ess,
                              bit erdy, logic [31:0] ebase, logic [63:0] edata,
                              logic [3:0] ecnt);
    vec_t v;
    v.rst = rst; v.ld = ld; v.la = la; v.sq = sq; v.st = st; v.sa = sa; v.sd = sd;
    v.rt = rt; v.dt = dt; v.md = md; v.ecmd = ecmd; v.eaddr = eaddr; v.ewd = ewd;
    v.els = els; v.ess = ess; v.erdy = erdy; v.ebase = ebase; v.edata = edata;
    v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Called just after a rising edge; drives one cycle and samples at the falling edge.
  task automatic apply(input vec_t v);
    reset = v.rst; ld_req = v.ld; ld_addr = v.la; ld_squash = v.sq;
    st_req = v.st; st_addr = v.sa; st_data = v.sd;
    mem_resp_tag = v.rt; mem_data_tag = v.dt; mem_data = v.md;
    #4;
    check("mem_cmd", {62'd0, mem_cmd}, {62'd0, v.ecmd});
    check("mem_addr", {32'd0, mem_addr}, {32'd0, v.eaddr});
    if (v.ecmd != 2'd1) check("mem_wdata", mem_wdata, v.ewd);
    check("ld_stall", {63'd0, ld_stall}, {63'd0, v.els});
    check("st_stall", {63'd0, st_stall}, {63'd0, v.ess});
    check("ld_data_ready", {63'd0, ld_data_ready}, {63'd0, v.erdy});
    if (v.erdy) begin
      check("ld_base_addr", {32'd0, ld_base_addr}, {32'd0, v.ebase});
      check("ld_data", ld_data, v.edata);
    end
    check("inflight_cnt", {60'd0, inflight_cnt}, {60'd0, v.ecnt});
    @(posedge clock); #1;
  endtask

  // Reference model: in-flight loads keyed by their memory tag.
  logic [31:0] m_addr [int];
  bit          m_sq   [int];
  int          m_starve;

  task automatic model_clear();
    m_addr.delete(); m_sq.delete(); m_starve = 0;
  endtask

  function automatic vec_t model_expect(vec_t v);
    bit starved, lg, sg, lacc, sacc, hit;
    starved = STARVE_ON && (m_starve == SL);
    lg   = !v.rst && v.ld && (m_addr.num() < OUT) && (!v.st || starved);
    sg   = !v.rst && v.st && !lg;
    lacc = lg && (v.rt != 0);
    sacc = sg && (v.rt != 0);
    hit  = (v.dt != 0) && m_addr.exists(int'(v.dt));
    v.ecmd  = lg ? 2'd1 : (sg ? 2'd2 : 2'd0);
    v.eaddr = lg ? v.la : (sg ? v.sa : 32'd0);
    v.ewd   = sg ? v.sd : 64'd0;
    v.els   = v.ld && !lacc;
    v.ess   = v.st && !sacc;
    v.erdy  = !v.rst && hit && !v.sq && !m_sq[int'(v.dt)];
    v.ebase = hit ? m_addr[int'(v.dt)] : 32'd0;
    v.edata = v.md;
    v.ecnt  = 4'(m_addr.num());
    return v;
  endfunction

  task automatic model_update(input vec_t v, input vec_t e);
    if (v.rst) begin
      model_clear();
      return;
    end
    if (v.dt != 0 && m_addr.exists(int'(v.dt))) begin
      m_addr.delete(int'(v.dt)); m_sq.delete(int'(v.dt));
    end
    if (v.sq) foreach (m_sq[k]) m_sq[k] = 1'b1;
    if (e.ecmd == 2'd1 && v.rt != 0) begin
      m_addr[int'(v.rt)] = v.la; m_sq[int'(v.rt)] = 1'b0;
    end
    if (v.ld && e.els) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
    else m_starve = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; ld_req = 0; ld_squash = 0; st_req = 0; ld_addr = 0; st_addr = 0;
    st_data = 0; mem_resp_tag = 0; mem_data_tag = 0; mem_data = 0;
    repeat (2) @(posedge clock);
    #1; reset = 1'b0;
    model_clear();
  endtask

  vec_t tbl [14];

  initial begin
    vec_t v, e;
    bit pend_ld, pend_st;
    logic [31:0] pl_addr, ps_addr, r32;
    logic [63:0] ps_data;
    int q[$];

    //             rst ld la        sq st sa       sd                     rt  dt  md     cmd addr      wdata                 ls ss rdy base      data   cnt
    tbl[0]  = mk(0, 0, 0,        0, 0, 0,       0,                     0,  0,  0,     0, 0,        0,                    0, 0, 0,  0,        0,     0);
    tbl[1]  = mk(0, 1, 'h100,    0, 0, 0,       0,                     3,  0,  0,     1, 'h100,    0,                    0, 0, 0,  0,        0,     0);
    tbl[2]  = mk(0, 0, 0,        0, 0, 0,       0,                     0,  0,  0,     0, 0,        0,                    0, 0, 0,  0,        0,     1);
    tbl[3]  = mk(0, 0, 0,        0, 0, 0,       0,                     0,  3,  'hAB,  0, 0,        0,                    0, 0, 1,  'h100,    'hAB,  1);
    tbl[4]  = mk(0, 0, 0,        0, 1, 'h200,   64'h1122334455667788,  1,  0,  0,     2, 'h200,    64'h1122334455667788, 0, 0, 0,  0,        0,     0);
    tbl[5]  = mk(0, 0, 0,        0, 1, 'h208,   64'h99,                0,  0,  0,     2, 'h208,    64'h99,               0, 1, 0,  0,        0,     0);
    tbl[6]  = mk(0, 1, 'h300,    0, 0, 0,       0,                     0,  0,  0,     1, 'h300,    0,                    1, 0, 0,  0,        0,     0);
    tbl[7]  = mk(0, 1, 'h300,    0, 0, 0,       0,                     0,  0,  0,     1, 'h300,    0,                    1, 0, 0,  0,        0,     0);
    tbl[8]  = mk(0, 1, 'h300,    0, 0, 0,       0,                     7,  0,  0,     1, 'h300,    0,                    0, 0, 0,  0,        0,     0);
    tbl[9]  = mk(0, 0, 0,        0, 0, 0,       0,                     0,  9,  'h55,  0, 0,        0,                    0, 0, 0,  0,        0,     1);
    tbl[10] = mk(0, 0, 0,        1, 0, 0,       0,                     0,  7,  'hCC,  0, 0,        0,                    0, 0, 0,  0,        0,     1);
    tbl[11] = mk(0, 0, 0,        0, 0, 0,       0,                     0,  0,  0,     0, 0,        0,                    0, 0, 0,  0,        0,     0);
    tbl[12] = mk(0, 1, 'h500,    0, 1, 'h400,   64'h5,                 2,  0,  0,     2, 'h400,    64'h5,                1, 0, 0,  0,        0,     0);
    tbl[13] = mk(0, 0, 0,        0, 0, 0,       0,                     0,  0,  0,     0, 0,        0,                    0, 0, 0,  0,        0,     0);

    do_reset();
    foreach (tbl[i]) apply(tbl[i]);

    // Table fills, then a same-cycle free still denies the waiting load.
    do_reset();
    for (int t = 1; t <= 4; t++)
      apply(mk(0, 1, 32'h1000 + 32'(t*8), 0, 0, 0, 0, 4'(t), 0, 0, 1, 32'h1000 + 32'(t*8), 0, 0, 0, 0, 0, 0, 4'(t-1)));
    apply(mk(0, 1, 'h2000, 0, 0, 0, 0, 5, 0, 0,     0, 0, 0, 1, 0, 0, 0, 0, 4));
    apply(mk(0, 1, 'h2000, 0, 0, 0, 0, 5, 2, 'h22,  0, 0, 0, 1, 0, 1, 'h1010, 'h22, 4));
    apply(mk(0, 1, 'h2000, 0, 0, 0, 0, 5, 0, 0,     1, 'h2000, 0, 0, 0, 0, 0, 0, 3));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, 4));

    // Squash suppresses older loads only.
    do_reset();
    apply(mk(0, 1, 'h500, 0, 0, 0, 0, 5, 0, 0,      1, 'h500, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 'h77,       0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 1, 'h600, 1, 0, 0, 0, 6, 0, 0,      1, 'h600, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 'h66,       0, 0, 0, 0, 0, 1, 'h600, 'h66, 1));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset with loads in flight drops their tags.
    do_reset();
    apply(mk(0, 1, 'h700, 0, 0, 0, 0, 1, 0, 0,      1, 'h700, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 1, 'h708, 0, 0, 0, 0, 2, 0, 0,      1, 'h708, 0, 0, 0, 0, 0, 0, 1));
    apply(mk(1, 1, 'h710, 0, 0, 0, 0, 3, 1, 'h11,   0, 0, 0, 1, 0, 0, 0, 0, 2));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 'h22,       0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h11,       0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Store and load both held: load gets through only once starved.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bit ld, lg;
      logic [31:0] sa;
      ld = STARVE_ON ? (c < 5) : 1'b1;
      lg = STARVE_ON && (c == 4);
      sa = 32'h800 + 32'(c*8);
      apply(mk(0, ld, 'h900, 0, 1, sa, 64'(c), 8, 0, 0,
               lg ? 2'd1 : 2'd2, lg ? 32'h900 : sa, lg ? 64'd0 : 64'(c),
               ld && !lg, lg, 0, 0, 0, (STARVE_ON && c == 5) ? 4'd1 : 4'd0));
    end

    // Random traffic against the reference model.
    do_reset();
    pend_ld = 0; pend_st = 0; pl_addr = 0; ps_addr = 0; ps_data = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!pend_ld && ($urandom_range(0, 2) != 0)) begin
        r32 = $urandom(); pl_addr = r32 & 32'hFFFF_FFF8; pend_ld = 1;
      end
      if (!pend_st && ($urandom_range(0, 2) == 0)) begin
        ps_addr = $urandom(); ps_data = {$urandom(), $urandom()}; pend_st = 1;
      end
      v = mk(($urandom_range(0, 299) == 0), pend_ld, pl_addr, ($urandom_range(0, 19) == 0),
             pend_st, ps_addr, ps_data, 0, 0, {$urandom(), $urandom()},
             0, 0, 0, 0, 0, 0, 0, 0, 0);
      if ($urandom_range(0, 3) != 0) begin
        do v.rt = 4'($urandom_range(1, 15)); while (m_addr.exists(int'(v.rt)));
      end
      q.delete();
      foreach (m_addr[k]) q.push_back(k);
      case ($urandom_range(0, 3))
        0, 1: if (q.size() > 0) v.dt = 4'(q[$urandom_range(0, q.size() - 1)]);
        2:    v.dt = 4'($urandom_range(1, 15));
        default: v.dt = 0;
      endcase
      e = model_expect(v);
      apply(e);
      model_update(v, e);
      if (e.ecmd == 2'd1 && !e.els) pend_ld = 0;
      if (e.ecmd == 2'd2 && !e.ess) pend_st = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
